// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs, ALU codes.
// Pure definitions; no latency or flow control of its own.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       iord;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, enables and selects out.
// Purely combinational wiring; no flow control.
interface mips_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/mips_aludec.sv
// ALU decoder: aluop/funct to alucontrol.
// Latency: combinational; no backpressure.
module mips_aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control: Moore FSM, per-state enables, ALU decode, PC enable.
// Latency: one state per clk (lw 5, sw/R/addi 4, beq/j 3, unknown 2); no backpressure.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mips_ctrl_if.master bus
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Unused encodings fall through to the all-zero default.
    always_comb begin
        c = '0;
        case (state_q)
            S_FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:   c.alusrcb = 2'b11;
            S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:    c.iord = 1'b1;
            S_MEMWB:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            S_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
            S_ALUWB:    begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB:   c.regwrite = 1'b1;
            S_JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:    c = '0;
        endcase
    end

    mips_aludec u_aludec (
        .aluop      (c.aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

    // Write enables are gated by reset directly so nothing pulses before the state clears.
    assign bus.pcen     = ~reset & (c.pcwrite | (c.branch & bus.zero));
    assign bus.irwrite  = ~reset & c.irwrite;
    assign bus.memwrite = ~reset & c.memwrite;
    assign bus.regwrite = ~reset & c.regwrite;
    assign bus.iord     = c.iord;
    assign bus.regdst   = c.regdst;
    assign bus.memtoreg = c.memtoreg;
    assign bus.alusrca  = c.alusrca;
    assign bus.alusrcb  = c.alusrcb;
    assign bus.pcsrc    = c.pcsrc;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with an expected-output scoreboard.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       pcen;
        logic       irwrite;
        logic       iord;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } obs_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   n_fail;
    obs_t exp_q[$];

    mips_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference outputs for a given state, written straight from the state table.
    function automatic obs_t model(input logic [3:0] s, input logic [5:0] fn,
                                   input logic z, input logic rst);
        obs_t o;
        o = '0;
        o.alucontrol = 3'b010;
        if (rst) begin
            o.alusrcb = 2'b01;
            return o;
        end
        o.state = s;
        case (s)
            4'd0:  begin o.irwrite = 1'b1; o.pcen = 1'b1; o.alusrcb = 2'b01; end
            4'd1:  o.alusrcb = 2'b11;
            4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd3:  o.iord = 1'b1;
            4'd4:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            4'd5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            4'd6: begin
                o.alusrca = 1'b1;
                case (fn)
                    6'b100010: o.alucontrol = 3'b110;
                    6'b100100: o.alucontrol = 3'b000;
                    6'b100101: o.alucontrol = 3'b001;
                    6'b101010: o.alucontrol = 3'b111;
                    default:   o.alucontrol = 3'b010;
                endcase
            end
            4'd7:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
            4'd8:  begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
            4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd10: o.regwrite = 1'b1;
            4'd11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state      = bus.state;
        o.pcen       = bus.pcen;
        o.irwrite    = bus.irwrite;
        o.iord       = bus.iord;
        o.memwrite   = bus.memwrite;
        o.regwrite   = bus.regwrite;
        o.regdst     = bus.regdst;
        o.memtoreg   = bus.memtoreg;
        o.alusrca    = bus.alusrca;
        o.alusrcb    = bus.alusrcb;
        o.pcsrc      = bus.pcsrc;
        o.alucontrol = bus.alucontrol;
        return o;
    endfunction

    task automatic check_next(input string tag);
        obs_t e;
        obs_t o;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, sample());
        end else begin
            e = exp_q.pop_front();
            o = sample();
            assert (o === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h (state %0d vs %0d)",
                       tag, o, e, o.state, e.state);
            end
        end
    endtask

    task automatic check_now(input string tag, input obs_t e);
        exp_q.push_back(e);
        check_next(tag);
    endtask

    // seq holds up to six 4-bit states, first state in the top nibble.
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int n, input logic [23:0] seq, input bit step_out);
        bus.op    = op;
        bus.funct = fn;
        bus.zero  = z;
        for (int i = 0; i < n; i++)
            exp_q.push_back(model(seq[23 - 4*i -: 4], fn, z, 1'b0));
        #1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                @(negedge clk);
                #1;
            end
            check_next($sformatf("%s_c%0d_s%0d", name, i, seq[23 - 4*i -: 4]));
        end
        if (step_out) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    logic [5:0] fn_list [6];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;
        fn_list   = '{FN_SUB, FN_SLT, FN_OR, FN_ADD, FN_AND, 6'b111111};

        #2;
        check_now("reset_state", model(4'd0, 6'b0, 1'b0, 1'b1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run("lw",  OP_LW, 6'b0, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 1);
        run("sw",  OP_SW, 6'b0, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 8'd0}, 1);
        run("sw_zero_ignored", OP_SW, 6'b0, 1'b1, 4, {4'd0, 4'd1, 4'd2, 4'd5, 8'd0}, 1);
        foreach (fn_list[k])
            run($sformatf("rtype_fn%b", fn_list[k]), OP_RTYPE, fn_list[k], 1'b0, 4,
                {4'd0, 4'd1, 4'd6, 4'd7, 8'd0}, 1);
        run("addi",     OP_ADDI, FN_SUB, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd10, 8'd0}, 1);
        run("beq_taken", OP_BEQ, 6'b0,   1'b1, 3, {4'd0, 4'd1, 4'd8, 12'd0}, 1);
        run("beq_not",  OP_BEQ,  6'b0,   1'b0, 3, {4'd0, 4'd1, 4'd8, 12'd0}, 1);
        run("j",        OP_J,    6'b0,   1'b0, 3, {4'd0, 4'd1, 4'd11, 12'd0}, 1);
        run("illegal",  6'b111111, 6'b0, 1'b0, 2, {4'd0, 4'd1, 16'd0}, 1);

        // Abandon an lw in MEMRD with an asynchronous mid-cycle reset.
        run("rst_lw", OP_LW, 6'b0, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd3, 8'd0}, 0);
        #2;
        reset = 1'b1;
        #1;
        check_now("rst_async", model(4'd0, 6'b0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        check_now("rst_hold", model(4'd0, 6'b0, 1'b0, 1'b1));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_now("rst_release_fetch", model(4'd0, 6'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_now("rst_first_edge_decode", model(4'd1, 6'b0, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        run("rst_resume", OP_LW, 6'b0, 1'b0, 3, {4'd2, 4'd3, 4'd4, 12'd0}, 1);

        check_now("final_fetch", model(4'd0, 6'b0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control unit for the multicycle MIPS datapath. It sequences the shared memory, ALU, register file, instruction register and the resettable 32-bit PC register. A Moore main FSM produces the per-state enables and mux selects. A combinational ALU decoder produces alucontrol. The PC enable is formed from pcwrite OR (branch AND zero).

Parameters:
(none; opcode, funct and state encodings are fixed constants in mips_ctrl_pkg)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clock clk
op  in  6  instr[31:26] from instruction register (stable from DECODE on)
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag (combinational from datapath)
pcen  out  1  PC register load enable
irwrite  out  1  instruction register load
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  data memory write
regwrite  out  1  register file write
regdst  out  1  write reg select: 0=rt, 1=rd
memtoreg  out  1  writeback select: 0=ALUOut, 1=Data
alusrca  out  1  0=PC, 1=A
alusrcb  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  4  current state (debug/verification)

Behaviour:
- The state register is cleared asynchronously to FETCH(0) when reset rises. While reset is high, irwrite, pcen, memwrite and regwrite are forced to 0. All other outputs take their FETCH values: alusrcb=01, all others 0, state=0.
- Outputs are Moore, decoded from state. Any signal not listed for a state is 0. aluop and branch are internal signals.
  - FETCH(0): irwrite=1, pcwrite=1, alusrcb=01, aluop=00
  - DECODE(1): alusrcb=11, aluop=00
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00
  - MEMRD(3): iord=1
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0
  - MEMWR(5): iord=1, memwrite=1
  - EXECUTE(6): alusrca=1, alusrcb=00, aluop=10
  - ALUWB(7): regwrite=1, regdst=1
  - BRANCH(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1
  - ADDIEXEC(9): alusrca=1, alusrcb=10, aluop=00
  - ADDIWB(10): regwrite=1, regdst=0, memtoreg=0
  - JUMP(11): pcsrc=10, pcwrite=1
- Transitions (one per rising clk edge):
  - FETCH->DECODE
  - DECODE: op 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP; any other op -> FETCH (treated as NOP, no writes).
  - MEMADR: op 100011 -> MEMRD, else -> MEMWR.
  - MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - Unused encodings 12-15 -> FETCH, with all enables 0.
- Latency per instruction, in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown 2.
- pcen = pcwrite | (branch & zero), combinational. zero is ignored outside BRANCH.
- ALU decoder (combinational):
  - aluop 00 -> 010.
  - aluop 01 -> 110.
  - aluop 10 -> by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct -> 010.
  - aluop 11 -> 010.
- Reset mid-instruction: reset is asynchronous, so the instruction is abandoned immediately. No write enable may pulse after reset rises. On the first clk edge after reset falls, the state moves to DECODE (FETCH has completed one cycle).

Decomposition:
- Package mips_ctrl_pkg holds: the state enum (4-bit, values above); opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J; funct constants; aluop and alucontrol codes.
- One natural sub-module: mips_aludec (aluop, funct -> alucontrol). The FSM, the output decode and pcen stay in mips_multicycle_ctrl.

Test Plan:
- Reset: assert reset mid-cycle while in MEMRD -> state=0 immediately; pcen, irwrite, memwrite, regwrite = 0 while reset high. Release reset -> next edge state=1.
- lw (op=100011) -> state sequence 0,1,2,3,4,0. iord=1 in state 3; regwrite=1 with memtoreg=1 only in state 4. pcen=1 only in state 0.
- sw (101011) -> sequence 0,1,2,5,0. memwrite=1 for exactly one cycle (state 5). regwrite never 1.
- R-type (op=0): funct 100010 -> alucontrol=110 in state 6 and regwrite=1 with regdst=1 in state 7. Repeat for funct 101010 -> 111 and 100101 -> 001.
- beq (000100): with zero=1 in state 8 -> pcen=1, pcsrc=01. With zero=0 -> pcen=0. Both cases return to state 0 after 3 cycles.
- j (000010) -> sequence 0,1,11,0 with pcsrc=10 and pcen=1 in state 11. Illegal op 111111 -> sequence 0,1,0 with no write enables asserted.
